// File: rtl/pixel_unpack_stream.sv
// pixel_unpack_stream: unpacks 32-bit words of 8-bit pixels into a one-pixel-per-cycle,
// raster-ordered stream with row/column position and frame markers.
module pixel_unpack_stream #(
  parameter int IMG_W = 227,
  parameter int IMG_H = 227,
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_restart,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_col,
  output logic [11:0] out_row,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic [15:0] frame_cnt
);
  logic [31:0] word_q;
  logic        full;
  logic [1:0]  byte_idx;
  logic [1:0]  sel;
  logic [11:0] col;
  logic [11:0] row;
  logic        at_eol;
  logic        at_eof;
  logic        last_in_word;
  logic        in_fire;
  logic        out_fire;
  assign at_eol       = col == 12'(IMG_W - 1);
  assign at_eof       = at_eol && row == 12'(IMG_H - 1);
  assign sel          = (LSB_FIRST != 0) ? byte_idx : ~byte_idx;
  assign out_pixel    = word_q[{sel, 3'b000} +: 8];
  assign out_valid    = full;
  assign out_col      = col;
  assign out_row      = row;
  assign out_sof      = full && col == 12'd0 && row == 12'd0;
  assign out_eol      = full && at_eol;
  assign out_eof      = full && at_eof;
  // the eof pixel retires its word early so the next frame starts on a fresh word
  assign last_in_word = byte_idx == 2'd3 || out_eof;
  assign in_ready     = !full || (out_ready && last_in_word);
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst || frame_restart) begin
      full     <= 1'b0;
      byte_idx <= 2'd0;
      col      <= 12'd0;
      row      <= 12'd0;
      if (rst) frame_cnt <= 16'd0;
    end else if (out_fire) begin
      if (last_in_word) begin
        byte_idx <= 2'd0;
        full     <= in_fire;
        if (in_fire) word_q <= in_word;
      end else begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (at_eof) begin
        col       <= 12'd0;
        row       <= 12'd0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (at_eol) begin
        col <= 12'd0;
        row <= row + 12'd1;
      end else begin
        col <= col + 12'd1;
      end
    end else if (in_fire) begin
      word_q   <= in_word;
      full     <= 1'b1;
      byte_idx <= 2'd0;
    end
  end
endmodule

// File: tb/tb_pixel_unpack_stream.sv
// tb_pixel_unpack_stream: directed checks on a 5x3 LSB-first, a 5x3 MSB-first and a default 227x227 instance.
module tb_pixel_unpack_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_restart = 1'b0;
  logic [31:0] in_word = 32'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        rdy [3];
  logic [7:0]  px [3];
  logic        vld [3];
  logic [11:0] col [3];
  logic [11:0] row [3];
  logic        sof [3];
  logic        eol [3];
  logic        eof [3];
  logic [15:0] fcnt [3];
  int          sel = 0;
  int          cur_w = 5;
  int          cur_h = 3;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] wq [$];
  logic [7:0]  eq [$];
  logic        o_valid, o_in_ready;
  logic [15:0] o_fcnt;
  logic [34:0] o_bus;
  always #5 clk = ~clk;
  pixel_unpack_stream #(.IMG_W(5), .IMG_H(3), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .frame_restart(frame_restart), .in_word(in_word), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_pixel(px[0]), .out_valid(vld[0]), .out_ready(out_ready), .out_col(col[0]),
    .out_row(row[0]), .out_sof(sof[0]), .out_eol(eol[0]), .out_eof(eof[0]), .frame_cnt(fcnt[0]));
  pixel_unpack_stream #(.IMG_W(5), .IMG_H(3), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .frame_restart(frame_restart), .in_word(in_word), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_pixel(px[1]), .out_valid(vld[1]), .out_ready(out_ready), .out_col(col[1]),
    .out_row(row[1]), .out_sof(sof[1]), .out_eol(eol[1]), .out_eof(eof[1]), .frame_cnt(fcnt[1]));
  pixel_unpack_stream u_big (
    .clk(clk), .rst(rst), .frame_restart(frame_restart), .in_word(in_word), .in_valid(in_valid),
    .in_ready(rdy[2]), .out_pixel(px[2]), .out_valid(vld[2]), .out_ready(out_ready), .out_col(col[2]),
    .out_row(row[2]), .out_sof(sof[2]), .out_eol(eol[2]), .out_eof(eof[2]), .frame_cnt(fcnt[2]));
  always_comb begin
    o_valid    = vld[sel];
    o_in_ready = rdy[sel];
    o_fcnt     = fcnt[sel];
    o_bus      = {px[sel], col[sel], row[sel], sof[sel], eol[sel], eof[sel]};
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    frame_restart = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask
  // push words whose bytes count up from base, byte 0 in bits [7:0]
  task automatic push_inc(input int base, input int n);
    for (int j = 0; j < n; j++)
      wq.push_back({8'(base + 4*j + 3), 8'(base + 4*j + 2), 8'(base + 4*j + 1), 8'(base + 4*j)});
  endtask
  // drive wq, expect eq in raster order from frame position 0
  task automatic stream(input string tag, input int max_cyc, input bit stall, output int bubbles);
    int c = 0;
    bit started = 0, hold = 0, fire_in;
    logic [34:0] prev = '0;
    logic [11:0] ex_col = 0, ex_row = 0;
    logic e_sof, e_eol, e_eof;
    bubbles = 0;
    while (eq.size() > 0 && c < max_cyc) begin
      in_valid = wq.size() > 0;
      in_word = in_valid ? wq[0] : 32'h0;
      out_ready = !stall || c % 4 == 0 || c % 4 == 3;
      #1;
      if (hold) check({tag, "_stall_hold"}, {o_valid, o_bus}, {1'b1, prev});
      if (o_valid && !out_ready) check({tag, "_stall_in_ready"}, o_in_ready, 0);
      if (started && !o_valid) bubbles++;
      hold = o_valid && !out_ready;
      prev = o_bus;
      fire_in = in_valid && o_in_ready;
      if (o_valid && out_ready) begin
        e_sof = ex_col == 0 && ex_row == 0;
        e_eol = ex_col == 12'(cur_w - 1);
        e_eof = e_eol && ex_row == 12'(cur_h - 1);
        check({tag, "_pixel"}, o_bus, {eq[0], ex_col, ex_row, e_sof, e_eol, e_eof});
        void'(eq.pop_front());
        started = 1;
        if (e_eof) begin
          ex_col = 0;
          ex_row = 0;
        end else if (e_eol) begin
          ex_col = 0;
          ex_row++;
        end else ex_col++;
      end
      if (fire_in) void'(wq.pop_front());
      step();
      c++;
    end
    if (eq.size() != 0) check({tag, "_timeout_left"}, eq.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask
  initial begin
    int bub;
    // reset state, 5x3 LSB-first unbroken stream
    sel = 0; cur_w = 5; cur_h = 3;
    do_reset();
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_in_ready", o_in_ready, 1);
    check("rst_fcnt", o_fcnt, 0);
    check("rst_sof", o_bus[2:0], 0);
    wq = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'hFF0E0D0C};
    eq.delete();
    for (int k = 0; k < 15; k++) eq.push_back(8'(k));
    stream("lsb", 100, 0, bub);
    #1;
    check("lsb_bubbles", bub, 0);
    check("lsb_fcnt", o_fcnt, 1);
    check("lsb_tail_dropped", o_valid, 0);
    // MSB-first byte order
    sel = 1;
    do_reset();
    wq = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0EFF};
    eq.delete();
    for (int k = 0; k < 15; k++) eq.push_back(8'(k));
    stream("msb", 100, 0, bub);
    #1;
    check("msb_bubbles", bub, 0);
    check("msb_fcnt", o_fcnt, 1);
    // downstream stalls over two frames; frame 2 starts on word 5 (byte value 16)
    sel = 0;
    do_reset();
    wq.delete();
    push_inc(0, 8);
    eq.delete();
    for (int k = 0; k < 15; k++) eq.push_back(8'(k));
    for (int k = 0; k < 15; k++) eq.push_back(8'(16 + k));
    stream("stall", 400, 1, bub);
    #1;
    check("stall_fcnt", o_fcnt, 2);
    // frame_restart after pixel 7, with a competing input word
    wq.delete();
    push_inc(0, 3);
    eq.delete();
    for (int k = 0; k < 8; k++) eq.push_back(8'(k));
    stream("pre_restart", 100, 0, bub);
    #1;
    check("pre_restart_valid", o_valid, 1);
    frame_restart = 1'b1;
    in_valid = 1'b1;
    in_word = 32'hDEADBEEF;
    out_ready = 1'b1;
    step();
    frame_restart = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("restart_valid", o_valid, 0);
    check("restart_in_ready", o_in_ready, 1);
    check("restart_fcnt", o_fcnt, 2);
    wq = '{32'h13121110};
    eq = '{8'h10, 8'h11};
    stream("post_restart", 50, 0, bub);
    #1;
    check("post_restart_fcnt", o_fcnt, 2);
    check("held_before_rst", o_valid, 1);
    // reset while holding a word
    do_reset();
    #1;
    check("rst_full_valid", o_valid, 0);
    check("rst_full_in_ready", o_in_ready, 1);
    check("rst_full_fcnt", o_fcnt, 0);
    check("rst_full_pos", o_bus[26:3], 0);
    // default 227x227 frame plus one word of the next frame
    sel = 2; cur_w = 227; cur_h = 227;
    do_reset();
    wq.delete();
    push_inc(0, 12884);
    eq.delete();
    for (int k = 0; k < 51529; k++) eq.push_back(8'(k));
    stream("big", 60000, 0, bub);
    #1;
    check("big_bubbles", bub, 0);
    check("big_fcnt", o_fcnt, 1);
    check("big_next_valid", o_valid, 1);
    check("big_next_sof", o_bus, {8'd76, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
